// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// The state encoding is reused by the bench to follow the controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hierarchy_full_subtractor.sv
// One-bit full subtractor cell: difference = a - b - c, with borrow-out.
module hierarchy_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic difference,
  output logic borrow
);

  assign difference = a ^ b ^ c;
  // Borrow when b alone exceeds a, or when a==b and a borrow is pending.
  assign borrow     = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one bit per clock, LSB first, through a single
// full-subtractor cell. Result and final borrow are registered.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fs_diff;
  logic             fs_brw;

  hierarchy_full_subtractor u_cell (
    .a          (a_q[0]),
    .b          (b_q[0]),
    .c          (brw_q),
    .difference (fs_diff),
    .borrow     (fs_brw)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Difference bits enter at the MSB so bit 0 lands at the LSB last.
        res_d = {fs_diff, res_q[WIDTH-1:1]};
        brw_d = fs_brw;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign difference = res_q;
  assign borrow     = brw_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl (WIDTH=8): directed and random
// subtractions, checked by a done-driven scoreboard.
module tb_serial_subtractor_ctrl;
  import serial_sub_pkg::*;

  localparam int W = 8;

  // Handshake: start is sampled only when the controller is IDLE; each
  // accepted start yields exactly one single-cycle done pulse, during which
  // difference/borrow carry the result.

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] difference;
  logic         borrow;
  logic [1:0]   state_dbg;

  int           cyc = 0;
  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           busy_run = 0;
  logic         prev_done = 1'b0;
  logic         mon_en = 1'b0;

  logic [W:0]   exp_q[$];
  int           exp_cyc_q[$];

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow     (borrow),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          logic [W:0] e;
          int         ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", {23'd0, borrow, difference}, {23'd0, e});
          check("latency", cyc, ec);
          check("busy_cycles", busy_run, W);
          check("busy_during_done", {31'd0, busy}, 32'd0);
        end
        busy_run = 0;
        if (prev_done) check("done_width", 32'd2, 32'd1);
      end
      if (busy) busy_run++;
      prev_done = done;
    end
  end

  // Driver tasks; each starts and ends just after a falling edge.
  task automatic wait_idle();
    for (int i = 0; i < 40 && state_dbg != 2'(IDLE); i++) @(negedge clk);
    if (state_dbg != 2'(IDLE)) check("idle_timeout", {30'd0, state_dbg}, 32'(IDLE));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W:0] exp);
    int e0;
    wait_idle();
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(posedge clk);
    #1;
    e0 = cyc;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(e0 + W);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   re;
    int           e0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, difference}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'(IDLE));
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op(8'h5A, 8'h23, 9'h037);
    run_op(8'h10, 8'h20, 9'h1F0);
    run_op(8'hFF, 8'hFF, 9'h000);
    run_op(8'h00, 8'h01, 9'h1FF);
    run_op(8'h80, 8'h7F, 9'h001);

    // start re-pulsed during RUN is ignored
    run_op(8'hC3, 8'h3C, 9'h087);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'h00;
    b     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("hold_diff", {24'd0, difference}, 32'h87);
    check("hold_borrow", {31'd0, borrow}, 32'd0);
    repeat (3) @(negedge clk);
    check("hold_diff_later", {24'd0, difference}, 32'h87);

    // Reset mid-RUN aborts with no done; start alongside rst is ignored
    run_op(8'h44, 8'h11, 9'h033);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h99;
    b     = 8'h11;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    busy_run = 0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, difference}, 32'd0);
    check("abort_borrow", {31'd0, borrow}, 32'd0);
    check("abort_state", {30'd0, state_dbg}, 32'(IDLE));
    rst   = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);
    run_op(8'h80, 8'h01, 9'h07F);

    // Back-to-back with start held high
    wait_idle();
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h23;
    @(posedge clk);
    #1;
    e0 = cyc;
    exp_q.push_back(9'h037);
    exp_cyc_q.push_back(e0 + W);
    exp_q.push_back(9'h1F0);
    exp_cyc_q.push_back(e0 + W + W + 2);
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    repeat (W + 2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    // Random pairs against (a-b) mod 256 and a<b
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      re[W-1:0] = ra - rb;
      re[W]     = (ra < rb);
      run_op(ra, rb, re);
    end

    // Drain outstanding results
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
